// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C configuration write master.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT,
    ACK,
    STOP,
    DONE
  } state_e;

  localparam logic        I2C_WRITE = 1'b0;
  localparam int unsigned NUM_BYTES = 3;

endpackage

// File: rtl/i2c_tick_gen.sv
// Free-running SCL quarter-period tick; clr restarts the count at zero.
module i2c_tick_gen #(
  parameter int CLK_DIV = 125
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int            W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0]  LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clr || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/i2c_cfg_master.sv
// Three-byte I2C register write master (device address, register, data).
// Optional SCL clock stretching is enabled by defining I2C_CLK_STRETCH_EN.
module i2c_cfg_master
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic       sda_drive,
  output logic       scl_drive,
  output logic       sda_val,
  output logic       scl_val,
  input  logic       sda_in,
  input  logic       scl_in
);

  localparam logic [1:0] LAST_BYTE = 2'(NUM_BYTES - 1);

  state_e     state_q, state_d;
  logic [1:0] ph_q, ph_d;
  logic [2:0] bit_q, bit_d;
  logic [1:0] byte_q, byte_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] reg_byte_q, reg_byte_d;
  logic [7:0] dat_byte_q, dat_byte_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       nack_q, nack_d;
  logic       sda_drive_q, sda_drive_d;
  logic       scl_drive_q, scl_drive_d;
  logic       accept, stall, tick;

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (accept | stall),
    .tick  (tick)
  );

`ifdef I2C_CLK_STRETCH_EN
  // Phase 2 is the first phase after SCL was released; wait there for the slave.
  assign stall = (ph_q == 2'd2) && !scl_in &&
                 ((state_q == BIT) || (state_q == ACK) || (state_q == STOP));
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign stall = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    sh_d        = sh_q;
    reg_byte_d  = reg_byte_q;
    dat_byte_d  = dat_byte_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    nack_d      = nack_q;
    sda_drive_d = sda_drive_q;
    scl_drive_d = scl_drive_q;
    accept      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          accept     = 1'b1;
          state_d    = START;
          busy_d     = 1'b1;
          nack_d     = 1'b0;
          ph_d       = 2'd0;
          bit_d      = 3'd0;
          byte_d     = 2'd0;
          sh_d       = {dev_addr, I2C_WRITE};
          reg_byte_d = reg_addr;
          dat_byte_d = wr_data;
        end
      end
      default: begin
        if (tick && !stall) begin
          ph_d = ph_q + 2'd1;
          case (state_q)
            START: begin
              if (ph_q == 2'd0) sda_drive_d = 1'b1;
              else begin
                scl_drive_d = 1'b1;
                state_d     = BIT;
                ph_d        = 2'd0;
              end
            end
            BIT: begin
              case (ph_q)
                2'd0: sda_drive_d = ~sh_q[7];
                2'd1: scl_drive_d = 1'b0;
                2'd2: ;
                default: begin
                  scl_drive_d = 1'b1;
                  sh_d        = {sh_q[6:0], 1'b0};
                  bit_d       = bit_q + 3'd1;
                  if (bit_q == 3'd7) state_d = ACK;
                end
              endcase
            end
            ACK: begin
              case (ph_q)
                2'd0: sda_drive_d = 1'b0;
                2'd1: scl_drive_d = 1'b0;
                2'd2: if (sda_in) nack_d = 1'b1;
                default: begin
                  scl_drive_d = 1'b1;
                  if (nack_q || (byte_q == LAST_BYTE)) state_d = STOP;
                  else begin
                    state_d = BIT;
                    byte_d  = byte_q + 2'd1;
                    sh_d    = (byte_q == 2'd0) ? reg_byte_q : dat_byte_q;
                  end
                end
              endcase
            end
            STOP: begin
              case (ph_q)
                2'd0: sda_drive_d = 1'b1;
                2'd1: scl_drive_d = 1'b0;
                2'd2: sda_drive_d = 1'b0;
                default: begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                end
              endcase
            end
            default: state_d = IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ph_q        <= 2'd0;
      bit_q       <= 3'd0;
      byte_q      <= 2'd0;
      sh_q        <= 8'd0;
      reg_byte_q  <= 8'd0;
      dat_byte_q  <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      nack_q      <= 1'b0;
      sda_drive_q <= 1'b0;
      scl_drive_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      sh_q        <= sh_d;
      reg_byte_q  <= reg_byte_d;
      dat_byte_q  <= dat_byte_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      nack_q      <= nack_d;
      sda_drive_q <= sda_drive_d;
      scl_drive_q <= scl_drive_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign nack      = nack_q;
  assign sda_drive = sda_drive_q;
  assign scl_drive = scl_drive_q;
  assign sda_val   = 1'b0;
  assign scl_val   = 1'b0;

endmodule

// File: tb/tb_i2c_cfg_master.sv
// Directed bench for i2c_cfg_master: open-drain bus model, byte monitor and ACK slave.
module tb_i2c_cfg_master;

  localparam int CLK_DIV = 4;
  // 2 START + 3 x (8 bits + ACK) x 4 + 4 STOP ticks
  localparam int FULL_LAT = 114 * CLK_DIV;
`ifdef I2C_CLK_STRETCH_EN
  localparam int STRETCH_LAT = FULL_LAT + 20;
`else
  localparam int STRETCH_LAT = FULL_LAT;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [6:0] dev_addr = 7'd0;
  logic [7:0] reg_addr = 8'd0;
  logic [7:0] wr_data = 8'd0;
  logic       busy, done, nack, sda_drive, scl_drive, sda_val, scl_val;
  logic       sda_in, scl_in, sda_bus, scl_bus;

  logic       slave_low = 1'b0;
  int         hold = 0;
  int         nack_idx = -1;
  logic       stretch_req = 1'b0;

  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  logic [7:0] mon_bytes [32];
  int         mon_n = 0;
  int         start_cnt = 0;
  int         stop_cnt = 0;
  int         last_rise = 0;

  i2c_cfg_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dev_addr  (dev_addr),
    .reg_addr  (reg_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .nack      (nack),
    .sda_drive (sda_drive),
    .scl_drive (scl_drive),
    .sda_val   (sda_val),
    .scl_val   (scl_val),
    .sda_in    (sda_in),
    .scl_in    (scl_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sda_bus = (sda_drive ? sda_val : 1'b1) & ~slave_low;
  assign scl_bus = scl_drive ? scl_val : 1'b1;
  assign sda_in  = sda_bus;
  assign scl_in  = scl_bus & (hold == 0);

  // Bus monitor plus ACKing slave; also stretches SCL (via scl_in) on request.
  logic       prev_sda = 1'b1, prev_scl = 1'b1, prev_drv = 1'b0, stretched = 1'b0;
  logic       sda_now, scl_now;
  logic [7:0] shreg = 8'd0;
  int         bitcnt = 0, bidx = 0;
  always @(negedge clk) begin
    sda_now = sda_bus;
    scl_now = scl_bus;
    if (reset) begin
      slave_low = 1'b0;
      hold      = 0;
      bitcnt    = 0;
    end else begin
      if (hold > 0) hold = hold - 1;
      if (scl_drive && !prev_drv) last_rise = cyc;
      if (prev_scl && scl_now && prev_sda && !sda_now) begin
        start_cnt = start_cnt + 1;
        bitcnt    = 0;
        bidx      = 0;
        stretched = 1'b0;
      end else if (prev_scl && scl_now && !prev_sda && sda_now) begin
        stop_cnt = stop_cnt + 1;
      end else if (!prev_scl && scl_now) begin
        if (bitcnt < 8) begin
          shreg  = {shreg[6:0], sda_now};
          bitcnt = bitcnt + 1;
          if (bitcnt == 8) begin
            mon_bytes[mon_n % 32] = shreg;
            mon_n = mon_n + 1;
          end
        end else begin
          bitcnt = 0;
          bidx   = bidx + 1;
        end
      end else if (prev_scl && !scl_now) begin
        if (bitcnt == 8 && bidx != nack_idx) slave_low = 1'b1;
        else if (bitcnt == 0) slave_low = 1'b0;
      end
      if (stretch_req && !stretched && bidx == 0 && bitcnt == 3 && !scl_drive && prev_drv) begin
        hold      = 20;
        stretched = 1'b1;
      end
    end
    prev_sda = sda_now;
    prev_scl = scl_now;
    prev_drv = scl_drive;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at #1 after a rising edge; returns with the request accepted.
  task automatic kick(input logic [6:0] d, input logic [7:0] r, input logic [7:0] w, output int t0);
    dev_addr = d;
    reg_addr = r;
    wr_data  = w;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0    = cyc;
  endtask

  task automatic wait_done(input int t0, output int lat, output logic nk);
    lat = -1;
    nk  = 1'bx;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = cyc - t0;
        nk  = nack;
        break;
      end
    end
  endtask

  int   t0, lat, b0, s0, p0;
  logic nk;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_nack", nack, 1'b0);
    check("rst_sda_drive", sda_drive, 1'b0);
    check("rst_scl_drive", scl_drive, 1'b0);
    check("rst_sda_val", sda_val, 1'b0);
    check("rst_scl_val", scl_val, 1'b0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", busy, 1'b0);

    // Full write, slave ACKs every byte
    b0 = mon_n; s0 = start_cnt; p0 = stop_cnt;
    kick(7'h50, 8'h12, 8'hA5, t0);
    check("t1_busy_next", busy, 1'b1);
    wait_done(t0, lat, nk);
    check("t1_latency", lat, FULL_LAT);
    check("t1_ticks_to_stop", last_rise - t0, 110 * CLK_DIV);
    check("t1_nack", nk, 1'b0);
    check("t1_busy_at_done", busy, 1'b0);
    check("t1_nbytes", mon_n - b0, 3);
    check("t1_byte0", mon_bytes[b0 % 32], 8'hA0);
    check("t1_byte1", mon_bytes[(b0 + 1) % 32], 8'h12);
    check("t1_byte2", mon_bytes[(b0 + 2) % 32], 8'hA5);
    check("t1_starts", start_cnt - s0, 1);
    check("t1_stops", stop_cnt - p0, 1);
    @(posedge clk);
    #1;
    check("t1_done_width", done, 1'b0);

    // Address NACK: STOP right after the first byte
    repeat (3) @(posedge clk);
    #1;
    nack_idx = 0;
    b0 = mon_n; p0 = stop_cnt;
    kick(7'h50, 8'h12, 8'hA5, t0);
    wait_done(t0, lat, nk);
    check("t2_latency", lat, 42 * CLK_DIV);
    check("t2_nack", nk, 1'b1);
    check("t2_nbytes", mon_n - b0, 1);
    check("t2_byte0", mon_bytes[b0 % 32], 8'hA0);
    check("t2_stops", stop_cnt - p0, 1);
    nack_idx = -1;

    // Second start and input changes during a transaction are ignored
    repeat (3) @(posedge clk);
    #1;
    b0 = mon_n; s0 = start_cnt; p0 = stop_cnt;
    kick(7'h21, 8'h34, 8'h5C, t0);
    check("t3_nack_cleared", nack, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    dev_addr = 7'h3C; reg_addr = 8'h99; wr_data = 8'h11; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("t3_busy_hold", busy, 1'b1);
    wait_done(t0, lat, nk);
    check("t3_latency", lat, FULL_LAT);
    check("t3_nbytes", mon_n - b0, 3);
    check("t3_byte0", mon_bytes[b0 % 32], 8'h42);
    check("t3_byte1", mon_bytes[(b0 + 1) % 32], 8'h34);
    check("t3_byte2", mon_bytes[(b0 + 2) % 32], 8'h5C);
    check("t3_starts", start_cnt - s0, 1);
    check("t3_stops", stop_cnt - p0, 1);

    // Start in the cycle right after done
    @(posedge clk);
    #1;
    check("t4_done_low", done, 1'b0);
    b0 = mon_n;
    kick(7'h7F, 8'h00, 8'hFF, t0);
    check("t4_busy_next", busy, 1'b1);
    wait_done(t0, lat, nk);
    check("t4_latency", lat, FULL_LAT);
    check("t4_byte0", mon_bytes[b0 % 32], 8'hFE);
    check("t4_byte1", mon_bytes[(b0 + 1) % 32], 8'h00);
    check("t4_byte2", mon_bytes[(b0 + 2) % 32], 8'hFF);

    // Reset in the middle of the register byte (SCL held low there)
    repeat (3) @(posedge clk);
    #1;
    b0 = mon_n; p0 = stop_cnt;
    kick(7'h50, 8'h12, 8'hA5, t0);
    repeat (190) @(posedge clk);
    #1;
    check("t5_busy_before", busy, 1'b1);
    check("t5_scl_low_before", scl_drive, 1'b1);
    check("t5_addr_byte", mon_bytes[b0 % 32], 8'hA0);
    reset = 1'b1;
    #1;
    check("t5_sda_released", sda_drive, 1'b0);
    check("t5_scl_released", scl_drive, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_done", done, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("t5_no_stop", stop_cnt - p0, 0);
    check("t5_nbytes", mon_n - b0, 1);

    // Slave stretches SCL for 20 clocks on bit 3 of the address byte
    repeat (3) @(posedge clk);
    #1;
    stretch_req = 1'b1;
    b0 = mon_n;
    kick(7'h50, 8'h12, 8'hA5, t0);
    wait_done(t0, lat, nk);
    stretch_req = 1'b0;
    check("t6_latency", lat, STRETCH_LAT);
    check("t6_nack", nk, 1'b0);
    check("t6_byte0", mon_bytes[b0 % 32], 8'hA0);
    check("t6_byte1", mon_bytes[(b0 + 1) % 32], 8'h12);
    check("t6_byte2", mon_bytes[(b0 + 2) % 32], 8'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
